// File: rtl/monster_shot_pool.sv
// monster_shot_pool: pool of falling monster shots with spawn, motion, retirement and per-pixel hit test
module monster_shot_pool #(
  parameter int NUM_SHOTS       = 4,
  parameter int OBJECT_WIDTH_X  = 2,
  parameter int OBJECT_HEIGHT_Y = 4,
  parameter int SPEED_Y         = 2,
  parameter int SCREEN_BOTTOM_Y = 480,
  localparam int IW = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 fireReq,
  input  logic signed [10:0]   fireX,
  input  logic signed [10:0]   fireY,
  input  logic                 collision,
  input  logic signed [10:0]   pixelX,
  input  logic signed [10:0]   pixelY,
  output logic                 fireAck,
  output logic                 fireDropped,
  output logic [10:0]          offsetX,
  output logic [10:0]          offsetY,
  output logic                 InsideRectangle,
  output logic [IW-1:0]        shotIndex,
  output logic [NUM_SHOTS-1:0] activeMask
);
  localparam logic signed [11:0] BOTTOM = 12'(SCREEN_BOTTOM_Y);
  localparam logic [11:0] SPEED = 12'(SPEED_Y);
  localparam logic [11:0] WID = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] HGT = 12'(OBJECT_HEIGHT_Y);
  logic [NUM_SHOTS-1:0] r_valid;
  logic signed [10:0] r_x [NUM_SHOTS];
  logic signed [10:0] r_y [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] w_hit;
  logic [11:0] w_dx [NUM_SHOTS];
  logic [11:0] w_dy [NUM_SHOTS];
  logic signed [11:0] w_ny [NUM_SHOTS];
  logic w_free;
  logic [IW-1:0] w_free_idx;
  logic w_any;
  logic [IW-1:0] w_idx;
  logic [10:0] w_ox;
  logic [10:0] w_oy;
  logic w_kill;
  assign activeMask = r_valid;
  assign w_kill = collision && InsideRectangle;
  // 12-bit differences keep negative positions correct; a non-negative
  // difference below the size means the pixel is inside
  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    assign w_dx[g] = {pixelX[10], pixelX} - {r_x[g][10], r_x[g]};
    assign w_dy[g] = {pixelY[10], pixelY} - {r_y[g][10], r_y[g]};
    assign w_ny[g] = {r_y[g][10], r_y[g]} + SPEED;
    assign w_hit[g] = r_valid[g] && !w_dx[g][11] && (w_dx[g] < WID)
                      && !w_dy[g][11] && (w_dy[g] < HGT);
  end
  // descending scans so the lowest index wins
  always_comb begin
    w_free = 1'b0;
    w_free_idx = '0;
    w_any = 1'b0;
    w_idx = '0;
    w_ox = '0;
    w_oy = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free = 1'b1;
        w_free_idx = IW'(i);
      end
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_idx = IW'(i);
        w_ox = w_dx[i][10:0];
        w_oy = w_dy[i][10:0];
      end
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
      fireAck <= 1'b0;
      fireDropped <= 1'b0;
      InsideRectangle <= 1'b0;
      shotIndex <= '0;
      offsetX <= '0;
      offsetY <= '0;
    end else begin
      fireAck <= fireReq && w_free;
      fireDropped <= fireReq && !w_free;
      InsideRectangle <= w_any;
      shotIndex <= w_idx;
      offsetX <= w_ox;
      offsetY <= w_oy;
      // spawn only touches free slots, so a stale collision index cannot kill a new shot
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (!r_valid[i]) begin
          if (fireReq && w_free && w_free_idx == IW'(i)) begin
            r_valid[i] <= 1'b1;
            r_x[i] <= fireX;
            r_y[i] <= fireY;
          end
        end else if (w_kill && shotIndex == IW'(i)) begin
          r_valid[i] <= 1'b0;
        end else if (startOfFrame) begin
          if (w_ny[i] >= BOTTOM) r_valid[i] <= 1'b0;
          else r_y[i] <= w_ny[i][10:0];
        end
      end
    end
  end
endmodule
